// File: rtl/regfile_param.sv
// ----------------------------------------------------------------------------
// regfile_param
//
// Per-core register file: two combinational read ports and one synchronous
// write port. It has hardwired zero, constant-one, core-ID and core-count
// registers, an optional same-cycle write-to-read bypass, and a sequenced
// sweep-clear operation with a ready handshake.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   core_id   in   [2:0]  this core's ID, captured every edge
//   no_cores  in   [2:0]  number of cores, captured every edge
//   rpa, rpb  in   [ADDR_W-1:0] read addresses
//   douta,doutb out [DATA_W-1:0] combinational read data
//   wp        in   [ADDR_W-1:0] write address
//   we        in   write enable
//   din       in   [DATA_W-1:0] write data
//   clr_req   in   request a sweep-clear of all writable registers
//   ready     out  1 = idle, accepting writes and clear requests
//   wr_err    out  one-cycle pulse: the previous cycle's write was rejected
// ----------------------------------------------------------------------------
module regfile_param #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 5,
    parameter int NUM_REGS      = 21,
    parameter int CORE_ID_REG   = 15,
    parameter int NUM_CORES_REG = 20,
    parameter int ONE_REG       = 19,
    parameter int BYPASS        = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        core_id,
    input  logic [2:0]        no_cores,
    input  logic [ADDR_W-1:0] rpa,
    input  logic [ADDR_W-1:0] rpb,
    output logic [DATA_W-1:0] douta,
    output logic [DATA_W-1:0] doutb,
    input  logic [ADDR_W-1:0] wp,
    input  logic              we,
    input  logic [DATA_W-1:0] din,
    input  logic              clr_req,
    output logic              ready,
    output logic              wr_err
);

    localparam logic [ADDR_W-1:0] ZERO_IDX   = '0;
    localparam logic [ADDR_W-1:0] ONE_IDX    = ADDR_W'(ONE_REG);
    localparam logic [ADDR_W-1:0] CID_IDX    = ADDR_W'(CORE_ID_REG);
    localparam logic [ADDR_W-1:0] NC_IDX     = ADDR_W'(NUM_CORES_REG);
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] FIRST_IDX  = ADDR_W'(1);
    // One extra bit so NUM_REGS == 2**ADDR_W is still representable.
    localparam logic [ADDR_W:0]   NUM_REGS_X = (ADDR_W + 1)'(NUM_REGS);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // True for indices that software may write and the sweep may clear.
    function automatic logic is_writable(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < NUM_REGS_X) &&
               (addr != ZERO_IDX) && (addr != ONE_IDX) &&
               (addr != CID_IDX)  && (addr != NC_IDX);
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] cnt_r;
    logic [ADDR_W-1:0] cnt_nxt_s;
    logic [DATA_W-1:0] mem_r  [NUM_REGS];
    logic [DATA_W-1:0] view_s [NUM_REGS];
    logic [2:0]        core_id_r;
    logic [2:0]        no_cores_r;
    logic              ready_r;
    logic              wr_err_r;
    logic              wp_ok_s;
    logic              wr_commit_s;
    logic              wr_rej_s;
    logic              clr_hit_s;
    logic              byp_s;
    logic [DATA_W-1:0] douta_s;
    logic [DATA_W-1:0] doutb_s;

    // Write qualification, rejection and sweep-clear strobes.
    always_comb begin
        wp_ok_s     = is_writable(wp);
        wr_commit_s = we && wp_ok_s && (state_r == ST_IDLE);
        wr_rej_s    = we && (!wp_ok_s || (state_r == ST_CLEAR));
        clr_hit_s   = (state_r == ST_CLEAR) && is_writable(cnt_r);
        // ready_r mirrors state_r == ST_IDLE, so it can gate the bypass.
        byp_s       = (BYPASS != 0) && ready_r && wr_commit_s;
    end

    // Next-state and sweep counter logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (clr_req) begin
                    state_nxt_s = ST_CLEAR;
                    cnt_nxt_s   = FIRST_IDX;
                end else begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = cnt_r;
                end
            end
            ST_CLEAR: begin
                if (cnt_r == LAST_IDX) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = ST_CLEAR;
                    cnt_nxt_s   = cnt_r + FIRST_IDX;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // State, counter, handshake and error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            ready_r    <= 1'b1;
            wr_err_r   <= 1'b0;
            core_id_r  <= 3'd0;
            no_cores_r <= 3'd0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            ready_r    <= (state_nxt_s == ST_IDLE);
            wr_err_r   <= wr_rej_s;
            core_id_r  <= core_id;
            no_cores_r <= no_cores;
        end
    end

    // Register storage: host writes in IDLE, one-entry-per-cycle clear in CLEAR.
    // Read-only entries are never selected by either strobe and stay at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_commit_s && (wp == ADDR_W'(i))) begin
                    mem_r[i] <= din;
                end else if (clr_hit_s && (cnt_r == ADDR_W'(i))) begin
                    mem_r[i] <= '0;
                end else begin
                    mem_r[i] <= mem_r[i];
                end
            end
        end
    end

    // Architectural view: hardwired entries override the storage array.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i == 0) begin
                view_s[i] = '0;
            end else if (i == ONE_REG) begin
                view_s[i] = DATA_W'(1);
            end else if (i == CORE_ID_REG) begin
                view_s[i] = DATA_W'(core_id_r);
            end else if (i == NUM_CORES_REG) begin
                view_s[i] = DATA_W'(no_cores_r);
            end else begin
                view_s[i] = mem_r[i];
            end
        end
    end

    // Read ports; out-of-range addresses fall through to zero.
    always_comb begin
        douta_s = '0;
        doutb_s = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            douta_s = (rpa == ADDR_W'(i)) ? view_s[i] : douta_s;
            doutb_s = (rpb == ADDR_W'(i)) ? view_s[i] : doutb_s;
        end
        douta_s = (byp_s && (rpa == wp)) ? din : douta_s;
        doutb_s = (byp_s && (rpb == wp)) ? din : doutb_s;
    end

    assign douta  = douta_s;
    assign doutb  = doutb_s;
    assign ready  = ready_r;
    assign wr_err = wr_err_r;

endmodule

// File: tb/tb_regfile_param.sv
// ----------------------------------------------------------------------------
// tb_regfile_param
//
// Drives a bypass and a non-bypass instance of regfile_param with the same
// stimulus. Each cycle the stimulus process pushes the expected outputs,
// computed from a behavioural model, into a queue; a monitor on the falling
// edge pops and compares them against both instances.
// ----------------------------------------------------------------------------
module tb_regfile_param;

    logic        clk;
    logic        rst_n;
    logic [2:0]  core_id;
    logic [2:0]  no_cores;
    logic [4:0]  rpa;
    logic [4:0]  rpb;
    logic [4:0]  wp;
    logic        we;
    logic [31:0] din;
    logic        clr_req;
    logic [31:0] douta1, doutb1, douta0, doutb0;
    logic        ready1, wr_err1, ready0, wr_err0;

    regfile_param #(.BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .core_id(core_id), .no_cores(no_cores),
        .rpa(rpa), .rpb(rpb), .douta(douta1), .doutb(doutb1),
        .wp(wp), .we(we), .din(din), .clr_req(clr_req),
        .ready(ready1), .wr_err(wr_err1)
    );

    regfile_param #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .core_id(core_id), .no_cores(no_cores),
        .rpa(rpa), .rpb(rpb), .douta(douta0), .doutb(doutb0),
        .wp(wp), .we(we), .din(din), .clr_req(clr_req),
        .ready(ready0), .wr_err(wr_err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a1, b1, a0, b0;
        logic        rdy, err;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    // ---------------- behavioural model ----------------
    logic [31:0] mreg [32];
    bit          clearing;
    int          sweep;
    bit          err_m;
    logic [2:0]  cid_m, nc_m;

    function automatic bit writable(input logic [4:0] a);
        return (a < 5'd21) && (a != 5'd0) && (a != 5'd15) && (a != 5'd19) && (a != 5'd20);
    endfunction

    function automatic logic [31:0] mread(input logic [4:0] a, input bit byp,
                                          input bit we_i, input logic [4:0] wp_i,
                                          input logic [31:0] din_i);
        if (a >= 5'd21) return 32'd0;
        if (byp && !clearing && we_i && writable(wp_i) && a == wp_i) return din_i;
        if (a == 5'd0)  return 32'd0;
        if (a == 5'd19) return 32'd1;
        if (a == 5'd15) return {29'd0, cid_m};
        if (a == 5'd20) return {29'd0, nc_m};
        return mreg[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
        clearing = 1'b0;
        sweep    = 0;
        err_m    = 1'b0;
        cid_m    = 3'd0;
        nc_m     = 3'd0;
    endtask

    task automatic model_step(input bit we_i, input logic [4:0] wp_i,
                              input logic [31:0] din_i, input bit clr_i,
                              input logic [2:0] cid, input logic [2:0] nc);
        bit new_err;
        new_err = we_i && (!writable(wp_i) || clearing);
        if (!clearing) begin
            if (we_i && writable(wp_i)) mreg[wp_i] = din_i;
            if (clr_i) begin
                clearing = 1'b1;
                sweep    = 1;
            end
        end else begin
            if (writable(5'(sweep))) mreg[sweep] = 32'd0;
            if (sweep == 20) clearing = 1'b0;
            else sweep = sweep + 1;
        end
        err_m = new_err;
        cid_m = cid;
        nc_m  = nc;
    endtask

    // One clock cycle of stimulus: drive, predict, queue, advance the model.
    task automatic cyc(input bit rst, input bit we_i, input logic [4:0] wp_i,
                       input logic [31:0] din_i, input logic [4:0] ra,
                       input logic [4:0] rb, input bit clr_i,
                       input logic [2:0] cid, input logic [2:0] nc);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n    = !rst;
        we       = we_i;
        wp       = wp_i;
        din      = din_i;
        rpa      = ra;
        rpb      = rb;
        clr_req  = clr_i;
        core_id  = cid;
        no_cores = nc;
        if (rst) model_reset();
        x.a1  = mread(ra, 1'b1, we_i, wp_i, din_i);
        x.b1  = mread(rb, 1'b1, we_i, wp_i, din_i);
        x.a0  = mread(ra, 1'b0, we_i, wp_i, din_i);
        x.b0  = mread(rb, 1'b0, we_i, wp_i, din_i);
        x.rdy = !clearing;
        x.err = err_m;
        exp_q.push_back(x);
        if (!rst) model_step(we_i, wp_i, din_i, clr_i, cid, nc);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // Monitor: compare every presented cycle against the queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("douta_byp",  douta1, e.a1);
            chk("doutb_byp",  doutb1, e.b1);
            chk("douta_nobyp", douta0, e.a0);
            chk("doutb_nobyp", doutb0, e.b0);
            chk("ready_byp",  {31'd0, ready1},  {31'd0, e.rdy});
            chk("ready_nobyp", {31'd0, ready0}, {31'd0, e.rdy});
            chk("wr_err_byp", {31'd0, wr_err1}, {31'd0, e.err});
            chk("wr_err_nobyp", {31'd0, wr_err0}, {31'd0, e.err});
        end
    end

    initial begin
        logic [4:0] bad [5];
        logic [4:0] w, ra;
        bad[0] = 5'd0; bad[1] = 5'd15; bad[2] = 5'd19; bad[3] = 5'd20; bad[4] = 5'd25;
        rst_n = 1'b0; we = 1'b0; wp = 5'd0; din = 32'd0; rpa = 5'd0; rpb = 5'd0;
        clr_req = 1'b0; core_id = 3'd0; no_cores = 3'd0;
        model_reset();

        // Reset, then core-ID/count capture and hardwired reads.
        cyc(1, 0, 0, 0, 15, 20, 0, 3'd3, 3'd4);
        cyc(1, 0, 0, 0, 15, 20, 0, 3'd3, 3'd4);
        cyc(0, 0, 0, 0, 15, 20, 0, 3'd3, 3'd4);
        cyc(0, 0, 0, 0, 15, 20, 0, 3'd3, 3'd4);
        cyc(0, 0, 0, 0, 19, 0, 0, 3'd3, 3'd4);
        cyc(0, 0, 0, 0, 7, 25, 0, 3'd3, 3'd4);

        // Write with same-cycle read, then read back.
        cyc(0, 1, 5, 32'hDEADBEEF, 5, 5, 0, 3'd3, 3'd4);
        cyc(0, 0, 0, 0, 5, 5, 0, 3'd3, 3'd4);
        cyc(0, 0, 0, 0, 5, 6, 0, 3'd3, 3'd4);

        // Rejected writes to read-only and out-of-range addresses.
        for (int i = 0; i < 5; i++) cyc(0, 1, bad[i], 32'h55, 25, bad[i], 0, 3'd3, 3'd4);
        cyc(0, 0, 0, 0, 25, 15, 0, 3'd3, 3'd4);
        cyc(0, 0, 0, 0, 19, 20, 0, 3'd3, 3'd4);

        // Fill 1..14, sweep-clear with a mid-sweep write and a core_id change.
        for (int i = 1; i <= 14; i++) cyc(0, 1, 5'(i), 32'hAA, 5'(i), 5'(i - 1), 0, 3'd3, 3'd4);
        cyc(0, 0, 0, 0, 1, 14, 1, 3'd3, 3'd4);
        for (int i = 1; i <= 22; i++) begin
            if (i == 5) cyc(0, 1, 3, 32'h1234, 3, 15, 1, 3'd6, 3'd4);
            else        cyc(0, 0, 0, 0, 5'(i), 15, 0, (i > 8) ? 3'd6 : 3'd3, 3'd4);
        end
        for (int i = 0; i < 21; i++) cyc(0, 0, 0, 0, 5'(i), 19, 0, 3'd6, 3'd4);

        // Refill a few, start sweep, reset at cycle 10, then a normal write.
        for (int i = 1; i <= 4; i++) cyc(0, 1, 5'(i), 32'hC0DE0000 + 32'(i), 5'(i), 2, 0, 3'd2, 3'd5);
        cyc(0, 0, 0, 0, 1, 2, 1, 3'd2, 3'd5);
        for (int i = 1; i < 10; i++) cyc(0, 0, 0, 0, 5'(i), 15, 0, 3'd2, 3'd5);
        cyc(1, 0, 0, 0, 4, 15, 0, 3'd2, 3'd5);
        cyc(0, 1, 9, 32'h0BADF00D, 9, 20, 0, 3'd2, 3'd5);
        cyc(0, 0, 0, 0, 9, 15, 0, 3'd2, 3'd5);

        // Clear request together with a write in IDLE.
        cyc(0, 1, 2, 32'd7, 2, 9, 1, 3'd2, 3'd5);
        for (int i = 0; i < 22; i++) cyc(0, 0, 0, 0, 2, 5'(i), 0, 3'd2, 3'd5);

        // Randomised traffic.
        for (int n = 0; n < 500; n++) begin
            w  = 5'($urandom_range(0, 31));
            ra = ($urandom_range(0, 3) == 0) ? w : 5'($urandom_range(0, 31));
            cyc(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)), w, $urandom,
                ra, 5'($urandom_range(0, 31)), ($urandom_range(0, 15) == 0),
                3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end

        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
